wallace_pass_sched: RTL and testbench

Pass scheduler for the Gaussian sample pool: loads the 1024-entry pool from host messages, then repeatedly sequences randomized in-place transform passes over it. It issues read-address quads to the 4-point transform datapath (add/sub, add/sub, ×±½). It tracks every in-flight quad across the transform latency and returns the matching write-back addresses when results emerge. It sits between the tausworth URNG, the host message port, the pool storage and the transform pipeline.

---
 rtl/wallace_pass_sched.sv | 212 +++++++++++++++++++++
 tb/tb_wallace_pass_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_pass_sched.sv
// Pass scheduler for the Gaussian sample pool: host load, seeded permuted transform passes, in-flight tracking.
// Optional AUTO_REPASS_EN: passes repeat back to back; otherwise each new pass waits for one host word.
module wallace_pass_sched #(
  parameter int N       = 1024,
  parameter int XB_SIZE = 32,
  parameter int LATENCY = 28,
  localparam int AW     = $clog2(N),
  localparam int QW     = 4 * AW
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        rand_word,
  input  logic               rand_valid,
  input  logic               pc_msg_valid,
  input  logic [XB_SIZE-1:0] pc_msg,
  output logic               pc_msg_ack,
  output logic               init_wren,
  output logic [AW-1:0]      init_addr,
  output logic [XB_SIZE-1:0] init_data,
  output logic               quad_nd,
  output logic [QW-1:0]      quad_rd_addr,
  input  logic               result_rdy,
  output logic               wb_wren,
  output logic [QW-1:0]      wb_addr,
  output logic               wb_half,
  output logic [1:0]         state,
  output logic               pass_done,
  output logic               error
);
  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_SEED = 2'd1, ST_RUN = 2'd2, ST_DRAIN = 2'd3} state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        ctr_q, ctr_d, start_q, start_d, stride_q, stride_d, mask_q, mask_d;
  logic [AW-3:0]        k_q, k_d;
  logic                 pc_msg_ack_q, pc_msg_ack_d, init_wren_q, init_wren_d;
  logic [AW-1:0]        init_addr_q, init_addr_d;
  logic [XB_SIZE-1:0]   init_data_q, init_data_d;
  logic                 quad_nd_q, quad_nd_d, quad_half_q, quad_half_d;
  logic [QW-1:0]        quad_addr_q, quad_addr_d;
  logic                 pass_done_q, pass_done_d, error_q, error_d;
  logic [LATENCY-1:0]   dl_v_q, dl_v_d, dl_half_q, dl_half_d;
  logic [QW-1:0]        dl_addr_q [LATENCY];
  logic [QW-1:0]        dl_addr_d [LATENCY];
`ifndef AUTO_REPASS_EN
  logic                 done_q, done_d;
`endif

  logic [AW-1:0]        seed_start, seed_stride, seed_mask, cur_start, cur_stride, cur_mask;
  logic [AW-3:0]        cur_k;
  logic [QW-1:0]        quad_calc;
  logic                 seeding, tail_busy, last_retiring;
  logic                 unused_rand;

  // Seed fields are carved MSB-first: start, stride (LSB forced to 1), mask.
  assign seed_start  = rand_word[31 -: AW];
  assign seed_stride = {rand_word[31-AW -: AW-1], 1'b1};
  assign seed_mask   = rand_word[32-2*AW -: AW];
  assign unused_rand = ^rand_word[32-3*AW:0];

  // Quad 0 is issued straight from the seed word so the first read follows the latch by one cycle.
  assign seeding    = (state_q == ST_SEED);
  assign cur_start  = seeding ? seed_start  : start_q;
  assign cur_stride = seeding ? seed_stride : stride_q;
  assign cur_mask   = seeding ? seed_mask   : mask_q;
  assign cur_k      = seeding ? '0 : k_q;

  always_comb begin
    quad_calc = '0;
    for (int j = 0; j < 4; j++) begin
      quad_calc[j*AW +: AW] = (cur_start + {cur_k, 2'(j)} * cur_stride) ^ cur_mask;
    end
  end

  // Final entry is one step from the head with nothing queued behind it.
  assign tail_busy     = quad_nd_q | (|dl_v_q[LATENCY-3:0]);
  assign last_retiring = !tail_busy && dl_v_q[LATENCY-2];

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    start_d      = start_q;
    stride_d     = stride_q;
    mask_d       = mask_q;
    k_d          = k_q;
    pc_msg_ack_d = 1'b0;
    init_wren_d  = 1'b0;
    init_addr_d  = init_addr_q;
    init_data_d  = init_data_q;
    quad_nd_d    = 1'b0;
    quad_addr_d  = quad_addr_q;
    quad_half_d  = quad_half_q;
    pass_done_d  = 1'b0;
    error_d      = error_q | (result_rdy ^ dl_v_q[LATENCY-1]);
    dl_v_d       = {dl_v_q[LATENCY-2:0], quad_nd_q};
    dl_half_d    = {dl_half_q[LATENCY-2:0], quad_half_q};
    dl_addr_d[0] = quad_addr_q;
    for (int i = 1; i < LATENCY; i++) dl_addr_d[i] = dl_addr_q[i-1];
`ifndef AUTO_REPASS_EN
    done_d       = done_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (pc_msg_valid) begin
          pc_msg_ack_d = 1'b1;
          init_wren_d  = 1'b1;
          init_addr_d  = ctr_q;
          init_data_d  = pc_msg;
          ctr_d        = ctr_q + AW'(1);
          if (ctr_q == AW'(N-1)) state_d = ST_SEED;
        end
      end
      ST_SEED: begin
        if (rand_valid) begin
          start_d     = seed_start;
          stride_d    = seed_stride;
          mask_d      = seed_mask;
          quad_nd_d   = 1'b1;
          quad_addr_d = quad_calc;
          quad_half_d = cur_k[AW-3];
          k_d         = (AW-2)'(1);
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        quad_nd_d   = 1'b1;
        quad_addr_d = quad_calc;
        quad_half_d = cur_k[AW-3];
        k_d         = k_q + (AW-2)'(1);
        if (k_q == '1) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
`ifdef AUTO_REPASS_EN
        if (last_retiring) begin
          pass_done_d = 1'b1;
          state_d     = ST_SEED;
        end
`else
        if (last_retiring) begin
          pass_done_d = 1'b1;
          done_d      = 1'b1;
        end else if (done_q && pc_msg_valid) begin
          pc_msg_ack_d = 1'b1;
          done_d       = 1'b0;
          state_d      = ST_SEED;
        end
`endif
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_INIT;
      ctr_q        <= '0;
      start_q      <= '0;
      stride_q     <= '0;
      mask_q       <= '0;
      k_q          <= '0;
      pc_msg_ack_q <= 1'b0;
      init_wren_q  <= 1'b0;
      init_addr_q  <= '0;
      init_data_q  <= '0;
      quad_nd_q    <= 1'b0;
      quad_addr_q  <= '0;
      quad_half_q  <= 1'b0;
      pass_done_q  <= 1'b0;
      error_q      <= 1'b0;
      dl_v_q       <= '0;
      dl_half_q    <= '0;
      for (int i = 0; i < LATENCY; i++) dl_addr_q[i] <= '0;
`ifndef AUTO_REPASS_EN
      done_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      start_q      <= start_d;
      stride_q     <= stride_d;
      mask_q       <= mask_d;
      k_q          <= k_d;
      pc_msg_ack_q <= pc_msg_ack_d;
      init_wren_q  <= init_wren_d;
      init_addr_q  <= init_addr_d;
      init_data_q  <= init_data_d;
      quad_nd_q    <= quad_nd_d;
      quad_addr_q  <= quad_addr_d;
      quad_half_q  <= quad_half_d;
      pass_done_q  <= pass_done_d;
      error_q      <= error_d;
      dl_v_q       <= dl_v_d;
      dl_half_q    <= dl_half_d;
      for (int i = 0; i < LATENCY; i++) dl_addr_q[i] <= dl_addr_d[i];
`ifndef AUTO_REPASS_EN
      done_q       <= done_d;
`endif
    end
  end

  assign pc_msg_ack   = pc_msg_ack_q;
  assign init_wren    = init_wren_q;
  assign init_addr    = init_addr_q;
  assign init_data    = init_data_q;
  assign quad_nd      = quad_nd_q;
  assign quad_rd_addr = quad_addr_q;
  assign wb_wren      = result_rdy & dl_v_q[LATENCY-1];
  assign wb_addr      = dl_addr_q[LATENCY-1];
  assign wb_half      = dl_half_q[LATENCY-1];
  assign state        = state_q;
  assign pass_done    = pass_done_q;
  assign error        = error_q;
endmodule

// File: tb/tb_wallace_pass_sched.sv
// Scoreboard bench for wallace_pass_sched: address model from the seed rules, result_rdy echoed LATENCY cycles later.
module tb_wallace_pass_sched;
  localparam int N = 1024, AW = 10, XB = 32, LAT = 28, NQ = N / 4, QW = 4 * AW;

  logic CLK = 1'b0;
  logic RESET, rand_valid, pc_msg_valid, result_rdy;
  logic [31:0] rand_word;
  logic [XB-1:0] pc_msg, init_data;
  logic pc_msg_ack, init_wren, quad_nd, wb_wren, wb_half, pass_done, error;
  logic [AW-1:0] init_addr;
  logic [QW-1:0] quad_rd_addr, wb_addr;
  logic [1:0] state;

  wallace_pass_sched #(.N(N), .XB_SIZE(XB), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .rand_word(rand_word), .rand_valid(rand_valid),
    .pc_msg_valid(pc_msg_valid), .pc_msg(pc_msg), .pc_msg_ack(pc_msg_ack),
    .init_wren(init_wren), .init_addr(init_addr), .init_data(init_data),
    .quad_nd(quad_nd), .quad_rd_addr(quad_rd_addr), .result_rdy(result_rdy),
    .wb_wren(wb_wren), .wb_addr(wb_addr), .wb_half(wb_half), .state(state),
    .pass_done(pass_done), .error(error));

  always #5 CLK = ~CLK;

  typedef struct { bit wren; int addr; logic [XB-1:0] data; int cyc; } init_t;
  typedef struct { logic [QW-1:0] addr; int cyc; int k; bit half; } quad_t;
  typedef struct { logic [QW-1:0] addr; bit half; } wb_t;

  init_t init_q[$];
  quad_t quad_q[$];
  wb_t   wb_q[$];
  bit    due[int];
  bit    seen[N];
  int    checks = 0, errors = 0;
  int    cyc = 0, distinct = 0, quads_in_pass = 0, pass_cnt = 0, last_quad_cyc = 0;
  int    drop_k = -1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference address rule: element i lands at ((start + i*stride) mod N) xor mask.
  function automatic logic [QW-1:0] model_quad(logic [31:0] r, int k);
    int start, stride, mask;
    logic [QW-1:0] q;
    start  = int'(r >> 22);
    stride = int'((r >> 13) & 32'h1FF) * 2 + 1;
    mask   = int'((r >> 3) & 32'h3FF);
    q = '0;
    for (int j = 0; j < 4; j++) q[j*AW +: AW] = AW'(((start + (4*k + j) * stride) % N) ^ mask);
    return q;
  endfunction

  // Transform stand-in: each accepted quad returns result_rdy exactly LAT cycles later.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    #1;
    result_rdy = due.exists(cyc) && !RESET;
  end

  always @(negedge CLK) begin
    quad_t qe;
    wb_t   we;
    init_t ie;
    int    a;
    if (!RESET && quad_nd) begin
      if (quad_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL quad_unexpected actual=%0h required=none", quad_rd_addr);
      end else begin
        qe = quad_q.pop_front();
        chk("quad_addr", quad_rd_addr, qe.addr);
        chk("quad_cycle", cyc, qe.cyc);
        for (int j = 0; j < 4; j++) begin
          a = int'(quad_rd_addr[j*AW +: AW]);
          if (!seen[a]) begin seen[a] = 1'b1; distinct++; end
        end
        quads_in_pass++;
        last_quad_cyc = cyc;
        if (qe.k != drop_k) begin
          due[cyc + LAT] = 1'b1;
          wb_q.push_back('{addr: qe.addr, half: qe.half});
        end
      end
    end
    if (!RESET && wb_wren) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected actual=%0h required=none", wb_addr);
      end else begin
        we = wb_q.pop_front();
        chk("wb_addr", wb_addr, we.addr);
        chk("wb_half", wb_half, we.half);
      end
    end
    if (!RESET && pass_done) begin
      chk("pass_done_cycle", cyc, last_quad_cyc + LAT);
      pass_cnt++;
    end
    if (!RESET && pc_msg_ack) begin
      if (init_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack_unexpected actual=1 required=0 state=%0d", state);
      end else begin
        ie = init_q.pop_front();
        chk("ack_cycle", cyc, ie.cyc);
        chk("init_wren", init_wren, ie.wren);
        if (ie.wren) begin
          chk("init_addr", init_addr, ie.addr);
          chk("init_data", init_data, ie.data);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic load_pool();
    for (int i = 0; i < N; i++) begin
      pc_msg_valid = 1'b1;
      pc_msg = $urandom;
      init_q.push_back('{wren: 1'b1, addr: i, data: pc_msg, cyc: cyc + 1});
      step(1);
    end
    pc_msg_valid = 1'b0;
  endtask

  task automatic kick();
    pc_msg_valid = 1'b1;
    pc_msg = $urandom;
    init_q.push_back('{wren: 1'b0, addr: 0, data: '0, cyc: cyc + 1});
    step(1);
    pc_msg_valid = 1'b0;
  endtask

  task automatic seed(logic [31:0] r, int gap);
    rand_valid = 1'b0;
    repeat (gap) begin rand_word = $urandom; step(1); end
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0;
    quads_in_pass = 0;
    rand_word = r;
    rand_valid = 1'b1;
    for (int k = 0; k < NQ; k++)
      quad_q.push_back('{addr: model_quad(r, k), cyc: cyc + 1 + k, k: k, half: (k >= NQ / 2)});
    step(1);
    rand_valid = 1'b0;
    rand_word = $urandom;
  endtask

  task automatic wait_pass(int budget);
    int start_cnt = pass_cnt;
    int n = 0;
    while (pass_cnt == start_cnt && n < budget) begin step(1); n++; end
    if (pass_cnt == start_cnt) begin
      checks++; errors++;
      $display("FAIL pass_done_timeout waited=%0d required=pass_done", n);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_state"}, state, 2'd0);
    chk({tag, "_quad_nd"}, quad_nd, 1'b0);
    chk({tag, "_quad_addr"}, quad_rd_addr, '0);
    chk({tag, "_wb_wren"}, wb_wren, 1'b0);
    chk({tag, "_wb_addr"}, wb_addr, '0);
    chk({tag, "_ack"}, pc_msg_ack, 1'b0);
    chk({tag, "_init_wren"}, init_wren, 1'b0);
    chk({tag, "_pass_done"}, pass_done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    int n;
    RESET = 1'b1; rand_valid = 1'b0; rand_word = '0; pc_msg_valid = 1'b0; pc_msg = '0; result_rdy = 1'b0;
    step(3);
    check_idle_outputs("reset");
    RESET = 1'b0;
    step(2);
    chk("post_reset_state", state, 2'd0);

    // Pass 1: identity seed, then ignored host words while waiting in SEED.
    load_pool();
    chk("state_after_load", state, 2'd1);
    pc_msg_valid = 1'b1;
    step(3);
    pc_msg_valid = 1'b0;
    seed(32'h0000_0000, 2);
    wait_pass(400);
    step(3);
    chk("wb_drained_p1", wb_q.size(), 0);
    chk("quad_drained_p1", quad_q.size(), 0);
    chk("distinct_p1", distinct, N);
`ifdef AUTO_REPASS_EN
    chk("state_after_pass", state, 2'd1);
`else
    chk("state_after_pass", state, 2'd3);
    kick();
`endif
    chk("error_p1", error, 1'b0);

    // Pass 2: all-ones seed fields must still form a permutation.
    seed(32'hFFFF_FFF8, 0);
    wait_pass(400);
    step(3);
    chk("distinct_p2", distinct, N);
    chk("wb_drained_p2", wb_q.size(), 0);
    chk("error_p2", error, 1'b0);
`ifndef AUTO_REPASS_EN
    kick();
`endif

    // Pass 3: random seed, one result pulse withheld.
    drop_k = $urandom_range(10, 240);
    seed($urandom, 5);
    wait_pass(400);
    drop_k = -1;
    step(3);
    chk("distinct_p3", distinct, N);
    chk("error_set", error, 1'b1);
    step(20);
    chk("error_sticky", error, 1'b1);

    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    step(1);
    chk("error_cleared", error, 1'b0);
    chk("state_after_reset", state, 2'd0);

    // Reset mid-pass discards in-flight quads.
    load_pool();
    seed($urandom, 1);
    n = 0;
    while (quads_in_pass < 100 && n < 400) begin step(1); n++; end
    if (quads_in_pass < 100) begin
      checks++; errors++;
      $display("FAIL quad100_timeout actual=%0d required=100", quads_in_pass);
    end
    #1;
    RESET = 1'b1;
    quad_q.delete(); wb_q.delete(); due.delete();
    #1;
    check_idle_outputs("midpass");
    step(3);
    RESET = 1'b0;
    step(60);
    chk("idle_state", state, 2'd0);
    chk("idle_error", error, 1'b0);

    load_pool();
    seed($urandom, 3);
    wait_pass(400);
    step(3);
    chk("distinct_p4", distinct, N);
    chk("wb_drained_p4", wb_q.size(), 0);
    chk("error_p4", error, 1'b0);
    chk("init_drained", init_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
